// File: rtl/ni_pkg.sv
// Shared types and helpers for the network-interface transmitter.
package ni_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE     = 3'd0;
  localparam state_t HDR_SET  = 3'd1;
  localparam state_t HDR_RTZ  = 3'd2;
  localparam state_t DATA_SET = 3'd3;
  localparam state_t DATA_RTZ = 3'd4;
  localparam state_t EOF_SET  = 3'd5;
  localparam state_t EOF_RTZ  = 3'd6;

  // Level driven on the EOF wire while the EOF token is presented.
  localparam logic EOF_TOKEN = 1'b1;

  function automatic logic [3:0] enc1of4(input logic [1:0] v);
    return 4'b0001 << v;
  endfunction

endpackage

// File: rtl/ack_sync.sv
// Two-flop synchroniser for a single asynchronous level.
module ack_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic s1_q, s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/ni_tx.sv
// Local-port transmitter: binary words in, 1-of-4 RTZ flits (header, payload, EOF) out.
module ni_tx
  import ni_pkg::*;
#(
  parameter int unsigned DW  = 16,
  parameter int unsigned SCN = DW / 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [DW-1:0]  in_data,
  input  logic           in_last,
  input  logic [3:0]     in_dst_x,
  input  logic [3:0]     in_dst_y,
  output logic [SCN-1:0] o0,
  output logic [SCN-1:0] o1,
  output logic [SCN-1:0] o2,
  output logic [SCN-1:0] o3,
  output logic           o4,
  input  logic           ia,
  output logic           busy,
  output logic [15:0]    frames_sent
);

  state_t               state_q, state_d;
  logic [DW-1:0]        data_q, data_d;
  logic                 last_q, last_d;
  logic [3:0][SCN-1:0]  sym_q, sym_d;
  logic                 o4_q, o4_d;
  logic                 busy_q, busy_d;
  logic [15:0]          frames_q, frames_d;
  logic                 ready_en_q;
  logic                 ack_s;
  logic                 accept;
  logic [DW-1:0]        enc_word;
  logic [3:0][SCN-1:0]  enc_sym;

  ack_sync u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (ia),
    .q_o   (ack_s)
  );

  // Holds in_ready low for the first cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_en_q <= 1'b0;
    else        ready_en_q <= 1'b1;
  end

  assign in_ready = ready_en_q &&
                    ((state_q == IDLE) || ((state_q == DATA_RTZ) && !ack_s && !last_q));
  assign accept   = in_valid && in_ready;

  // Word to be encoded onto the wires on the next set transition.
  always_comb begin
    enc_word = '0;
    unique case (state_q)
      IDLE:     enc_word[7:0] = {in_dst_y, in_dst_x};
      HDR_RTZ:  enc_word      = data_q;
      DATA_RTZ: enc_word      = in_data;
      default:  enc_word      = '0;
    endcase
  end

  always_comb begin
    logic [3:0] oh;
    oh      = '0;
    enc_sym = '0;
    for (int j = 0; j < SCN; j++) begin
      oh = enc1of4(enc_word[2*j +: 2]);
      for (int v = 0; v < 4; v++) enc_sym[v][j] = oh[v];
    end
  end

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    last_d   = last_q;
    sym_d    = sym_q;
    o4_d     = o4_q;
    busy_d   = busy_q;
    frames_d = frames_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          data_d  = in_data;
          last_d  = in_last;
          sym_d   = enc_sym;
          busy_d  = 1'b1;
          state_d = HDR_SET;
        end
      end
      HDR_SET: begin
        if (ack_s) begin
          sym_d   = '0;
          state_d = HDR_RTZ;
        end
      end
      HDR_RTZ: begin
        if (!ack_s) begin
          sym_d   = enc_sym;
          state_d = DATA_SET;
        end
      end
      DATA_SET: begin
        if (ack_s) begin
          sym_d   = '0;
          state_d = DATA_RTZ;
        end
      end
      DATA_RTZ: begin
        if (!ack_s) begin
          if (last_q) begin
            o4_d    = EOF_TOKEN;
            state_d = EOF_SET;
          end else if (in_valid) begin
            data_d  = in_data;
            last_d  = in_last;
            sym_d   = enc_sym;
            state_d = DATA_SET;
          end
        end
      end
      EOF_SET: begin
        if (ack_s) begin
          o4_d    = 1'b0;
          state_d = EOF_RTZ;
        end
      end
      EOF_RTZ: begin
        if (!ack_s) begin
          frames_d = frames_q + 16'd1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end
      end
      default: begin
        sym_d   = '0;
        o4_d    = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      data_q   <= '0;
      last_q   <= 1'b0;
      sym_q    <= '0;
      o4_q     <= 1'b0;
      busy_q   <= 1'b0;
      frames_q <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      last_q   <= last_d;
      sym_q    <= sym_d;
      o4_q     <= o4_d;
      busy_q   <= busy_d;
      frames_q <= frames_d;
    end
  end

  assign o0          = sym_q[0];
  assign o1          = sym_q[1];
  assign o2          = sym_q[2];
  assign o3          = sym_q[3];
  assign o4          = o4_q;
  assign busy        = busy_q;
  assign frames_sent = frames_q;

endmodule

// File: doc/ni_tx.md
Name: ni_tx

Overview:
- Clocked network-interface transmitter for the local port of a router tile.
- Accepts binary words from the processing element over a valid/ready interface.
- Converts each frame into 1-of-4 encoded flits: header, payload, then a standalone EOF token.
- Drives them with a four-phase return-to-zero handshake into the local-port input buffer; non-sliced configuration, so one ack wire and one EOF wire.

Parameters:
- DW, 16: flit data width in bits; must be even and >= 8.
- SCN, DW/2: number of 1-of-4 symbols per flit.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  PE word valid
- in_ready  output  1  PE word accepted when in_valid && in_ready at posedge
- in_data  input  DW  payload word
- in_last  input  1  marks last payload word of a frame
- in_dst_x  input  4  destination x, binary; sampled with first word of frame
- in_dst_y  input  4  destination y, binary; sampled with first word of frame
- o0, o1, o2, o3  output  SCN each  1-of-4 data wires; symbol j is on bit j
- o4  output  1  EOF token wire
- ia  input  1  asynchronous ack from input buffer
- busy  output  1  a frame is in progress
- frames_sent  output  16  count of completed frames; wraps

Behaviour:
- Reset (async, rst_n=0):
  - o0..o4=0, in_ready=0, busy=0, frames_sent=0.
  - State IDLE; synchroniser flops 0; holding register empty.
  - Outputs go low immediately on reset, including mid-frame; the receiver is reset by the same rst_n.
- All of o0..o4 come straight from flops. No combinational path from any input to them.
- ia passes through a two-flop synchroniser to give ack_s. Ack is seen 2-3 clk after ia changes.
- Encoding: symbol value v in 0..3 drives o<v>[j]=1; the other three wires of symbol j are 0.
- Payload symbol j = in_data[2j+1:2j].
- Header flit:
  - Symbol 0 = dst_x[1:0], symbol 1 = dst_x[3:2].
  - Symbol 2 = dst_y[1:0], symbol 3 = dst_y[3:2].
  - Symbols 4..SCN-1 = value 0.
- EOF token: o4=1 with o0..o3 all 0.
- Token cycle for every flit and for EOF: set wires, wait for ack_s=1, clear all wires to zero, wait for ack_s=0.
  - Next token is never set while ack_s=1.
  - Wires are never changed while ack_s is waited on.
- in_ready=1 only in IDLE, or in DATA_RTZ when ack_s=0 and the current word is not last. At most one word is buffered.
- FSM states:
  - IDLE: in_ready=1. On accept, store word, dst and last; busy=1 -> HDR_SET.
  - HDR_SET: drive header. When ack_s=1 -> HDR_RTZ with wires cleared.
  - HDR_RTZ: when ack_s=0 -> DATA_SET.
  - DATA_SET: drive the held word. When ack_s=1 -> DATA_RTZ with wires cleared.
  - DATA_RTZ: when ack_s=0:
    - held word was last -> EOF_SET.
    - otherwise, if in_valid -> accept next word, DATA_SET in the following cycle.
    - otherwise stay (in_ready held 1).
  - EOF_SET: o4=1. When ack_s=1 -> EOF_RTZ with o4=0.
  - EOF_RTZ: when ack_s=0 -> IDLE; frames_sent+1 (mod 2^16); busy=0.
- Minimum frame is one word plus header plus EOF, i.e. three tokens.
- There is no frame length limit.
- in_dst_x/in_dst_y are ignored on non-first words.
- in_last on the first word is legal: header, one data flit, EOF.
- ia that is stuck or spurious is not detected; the FSM waits indefinitely. Flagging it is bench responsibility.

Decomposition:
- Shared package ni_pkg holds:
  - state enum (IDLE, HDR_SET, HDR_RTZ, DATA_SET, DATA_RTZ, EOF_SET, EOF_RTZ);
  - function enc1of4 (2-bit value to 4-bit one-hot);
  - constant EOF_TOKEN.
- One sub-module, ack_sync: two-flop synchroniser with async active-low reset, reused for other async-to-clock crossings.

Test Plan:
- Reset mid-frame: assert rst_n=0 during DATA_SET -> o0..o4=0 in the same timestep; state IDLE; frames_sent=0; in_ready=0 until release.
- Single-word frame: dst_x=4'b1001, dst_y=4'b0110, in_data=16'h1B00, in_last=1; the bench model acks each token 5 clk after set/clear:
  - header: o1[0], o2[1], o2[2], o1[3] high and o0[7:4] high;
  - data: symbol0..3 = 0, symbols 4..7 = 3,2,1,0;
  - then EOF token with o4=1;
  - frames_sent=1.
- Three-word frame with slow ack (20 clk): in_ready never asserted while ack_s=1; exactly 5 tokens; every token preceded by an all-zero state.
- Ack faster than the clock (ia follows outputs with 1 ns delay): no token lost or duplicated; order header, w0, w1, w2, EOF.
- in_valid gaps: in_valid low for 10 clk between words -> FSM holds DATA_RTZ with wires 0, then resumes; busy=1 throughout.
- Counter wrap: preset via 65536 one-word frames (or force) -> frames_sent wraps 16'hFFFF -> 16'h0000.
